// File: rtl/lvt_mpram_pkg.sv
// Shared types, default parameters and helpers for the live-value-table multi-port RAM.
package lvt_mpram_pkg;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam int NW_DEF    = 2;
    localparam int NR_DEF    = 1;
    localparam int DEPTH_DEF = 128;
    localparam int DW_DEF    = 8;

    // LVT entries need at least one bit even when $clog2 would return 0.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/lvt_bank.sv
// Simple dual-port 1W1R bank RAM with synchronous read-first registered output.
module lvt_bank #(
    parameter  int DW    = 8,
    parameter  int DEPTH = 128,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic          re_i,
    input  logic [AW-1:0] raddr_i,
    output logic [DW-1:0] rdata_o
);

    logic [DW-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_o <= mem_q[raddr_i];
        end
    end

endmodule

// File: rtl/lvt_mpram.sv
// NW-write / NR-read RAM built from NW*NR 1W1R banks and a register-based live value table.
module lvt_mpram
    import lvt_mpram_pkg::*;
#(
    parameter  int NW    = NW_DEF,
    parameter  int NR    = NR_DEF,
    parameter  int DEPTH = DEPTH_DEF,
    parameter  int DW    = DW_DEF,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NW-1:0]    wr_en,
    input  logic [NW*AW-1:0] wr_addr,
    input  logic [NW*DW-1:0] wr_data,
    input  logic [NR-1:0]    rd_en,
    input  logic [NR*AW-1:0] rd_addr,
    output logic [NR*DW-1:0] rd_data,
    output logic [NR-1:0]    rd_valid,
    output logic             init_busy
);

    localparam int LW = clog2_min1(NW);

    state_t        state_q;
    logic [AW-1:0] cnt_q;
    logic          busy_q;
    logic [NR-1:0] rd_valid_q;
    logic [NR-1:0] hold_q;
    logic          run;

    logic [LW-1:0] lvt_q     [DEPTH];
    logic [LW-1:0] lvt_sel_q [NR];
    logic [DW-1:0] bank_rd   [NR][NW];

    assign run = (state_q == ST_RUN);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_INIT;
            cnt_q      <= '0;
            busy_q     <= 1'b1;
            rd_valid_q <= '0;
            hold_q     <= '0;
        end else begin
            case (state_q)
                ST_INIT: begin
                    cnt_q      <= cnt_q + 1'b1;
                    rd_valid_q <= '0;
                    if (cnt_q == AW'(DEPTH - 1)) begin
                        state_q <= ST_RUN;
                        busy_q  <= 1'b0;
                    end
                end
                ST_RUN: begin
                    rd_valid_q <= rd_en;
                    hold_q     <= hold_q | rd_en;
                end
                default: state_q <= ST_INIT;
            endcase
        end
    end

    // Ascending loop: the last non-blocking write wins, so the highest port owns a conflict.
    always_ff @(posedge clk) begin
        if (!run) begin
            lvt_q[cnt_q] <= '0;
        end else begin
            for (int unsigned i = 0; i < NW; i++) begin
                if (wr_en[i]) begin
                    lvt_q[wr_addr[i*AW +: AW]] <= LW'(i);
                end
            end
        end
        for (int unsigned j = 0; j < NR; j++) begin
            if (run && rd_en[j]) begin
                lvt_sel_q[j] <= lvt_q[rd_addr[j*AW +: AW]];
            end
        end
    end

    for (genvar gj = 0; gj < NR; gj++) begin : g_row
        for (genvar gi = 0; gi < NW; gi++) begin : g_col
            lvt_bank #(
                .DW    (DW),
                .DEPTH (DEPTH)
            ) u_bank (
                .clk_i   (clk),
                .we_i    (run ? wr_en[gi] : 1'b1),
                .waddr_i (run ? wr_addr[gi*AW +: AW] : cnt_q),
                .wdata_i (run ? wr_data[gi*DW +: DW] : '0),
                .re_i    (run & rd_en[gj]),
                .raddr_i (rd_addr[gj*AW +: AW]),
                .rdata_o (bank_rd[gj][gi])
            );
        end
    end

    // Bank outputs are unreset, so a port shows zero until its first read after reset.
    always_comb begin
        rd_data = '0;
        for (int unsigned j = 0; j < NR; j++) begin
            if (hold_q[j]) begin
                rd_data[j*DW +: DW] = bank_rd[j][lvt_sel_q[j]];
            end
        end
    end

    assign rd_valid  = rd_valid_q;
    assign init_busy = busy_q;

endmodule

// File: tb/tb_lvt_mpram.sv
// Scoreboard bench for lvt_mpram with two write ports and two read ports.
module tb_lvt_mpram;

    localparam int NW = 2;
    localparam int NR = 2;
    localparam int DEPTH = 128;
    localparam int DW = 8;
    localparam int AW = 7;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [NW-1:0]    wr_en = '0;
    logic [NW*AW-1:0] wr_addr = '0;
    logic [NW*DW-1:0] wr_data = '0;
    logic [NR-1:0]    rd_en = '0;
    logic [NR*AW-1:0] rd_addr = '0;
    logic [NR*DW-1:0] rd_data;
    logic [NR-1:0]    rd_valid;
    logic             init_busy;

    int n_checks = 0;
    int n_fail   = 0;
    logic [7:0] exp_q0[$];
    logic [7:0] exp_q1[$];

    lvt_mpram #(
        .NW    (NW),
        .NR    (NR),
        .DEPTH (DEPTH),
        .DW    (DW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .rd_en     (rd_en),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .init_busy (init_busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One bus cycle: drive after the edge, sampled at the next edge; expectations queued when chk.
    task automatic cyc(input logic [1:0] we, input logic [6:0] wa0, input logic [7:0] wd0,
                       input logic [6:0] wa1, input logic [7:0] wd1,
                       input logic [1:0] re, input logic [6:0] ra0, input logic [6:0] ra1,
                       input logic [7:0] e0, input logic [7:0] e1, input bit chk);
        @(posedge clk);
        #1;
        wr_en   = we;
        wr_addr = {wa1, wa0};
        wr_data = {wd1, wd0};
        rd_en   = re;
        rd_addr = {ra1, ra0};
        if (chk && re[0]) exp_q0.push_back(e0);
        if (chk && re[1]) exp_q1.push_back(e1);
    endtask

    task automatic idle();
        cyc(2'b00, 7'd0, 8'h00, 7'd0, 8'h00, 2'b00, 7'd0, 7'd0, 8'h00, 8'h00, 1'b0);
    endtask

    task automatic count_init(output int n);
        n = 0;
        for (int c = 0; c < 1000; c++) begin
            @(negedge clk);
            if (init_busy) n++;
            else break;
        end
    endtask

    // Monitor: every rd_valid strobe must match the oldest queued expectation for that port.
    always @(negedge clk) begin
        if (rd_valid[0]) begin
            if (exp_q0.size() == 0) check("rd0_unexpected_valid", 32'(rd_valid[0]), 32'd0);
            else check("rd0_data", 32'(rd_data[7:0]), 32'(exp_q0.pop_front()));
        end
        if (rd_valid[1]) begin
            if (exp_q1.size() == 0) check("rd1_unexpected_valid", 32'(rd_valid[1]), 32'd0);
            else check("rd1_data", 32'(rd_data[15:8]), 32'(exp_q1.pop_front()));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        #1 rst = 1'b0;
        #1;
        check("reset_busy", 32'(init_busy), 32'd1);
        check("reset_valid", 32'(rd_valid), 32'd0);
        check("reset_data", 32'(rd_data), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;

        fork
            count_init(n);
            begin
                repeat (10) @(posedge clk);
                #1;
                rd_en   = 2'b11;
                rd_addr = {7'd5, 7'd5};
                @(posedge clk);
                #1;
                rd_en = 2'b00;
            end
        join
        check("init_cycles", 32'(n), 32'd128);

        // read after init returns cleared contents
        cyc(2'b00, 7'd0, 8'h00, 7'd0, 8'h00, 2'b11, 7'd5, 7'd5, 8'h00, 8'h00, 1'b1);
        // basic write then read
        cyc(2'b01, 7'd10, 8'h05, 7'd0, 8'h00, 2'b00, 7'd0, 7'd0, 8'h00, 8'h00, 1'b0);
        cyc(2'b00, 7'd0, 8'h00, 7'd0, 8'h00, 2'b01, 7'd10, 7'd0, 8'h05, 8'h00, 1'b1);
        idle();
        idle();
        @(negedge clk);
        check("hold_data", 32'(rd_data[7:0]), 32'h05);
        check("valid_dropped", 32'(rd_valid), 32'd0);

        // live-value tracking
        cyc(2'b01, 7'd20, 8'h11, 7'd0, 8'h00, 2'b00, 7'd0, 7'd0, 8'h00, 8'h00, 1'b0);
        cyc(2'b10, 7'd0, 8'h00, 7'd20, 8'h22, 2'b00, 7'd0, 7'd0, 8'h00, 8'h00, 1'b0);
        cyc(2'b00, 7'd0, 8'h00, 7'd0, 8'h00, 2'b11, 7'd20, 7'd20, 8'h22, 8'h22, 1'b1);
        cyc(2'b01, 7'd20, 8'h33, 7'd0, 8'h00, 2'b00, 7'd0, 7'd0, 8'h00, 8'h00, 1'b0);
        cyc(2'b00, 7'd0, 8'h00, 7'd0, 8'h00, 2'b11, 7'd20, 7'd20, 8'h33, 8'h33, 1'b1);

        // same-address conflict: port 1 wins
        cyc(2'b11, 7'd30, 8'hAA, 7'd30, 8'hBB, 2'b00, 7'd0, 7'd0, 8'h00, 8'h00, 1'b0);
        cyc(2'b00, 7'd0, 8'h00, 7'd0, 8'h00, 2'b11, 7'd30, 7'd30, 8'hBB, 8'hBB, 1'b1);

        // read-during-write returns old data, LVT and bank both read-first
        cyc(2'b10, 7'd0, 8'h00, 7'd40, 8'h22, 2'b00, 7'd0, 7'd0, 8'h00, 8'h00, 1'b0);
        cyc(2'b01, 7'd40, 8'h44, 7'd0, 8'h00, 2'b11, 7'd40, 7'd40, 8'h22, 8'h22, 1'b1);
        cyc(2'b01, 7'd40, 8'h55, 7'd0, 8'h00, 2'b11, 7'd40, 7'd40, 8'h44, 8'h44, 1'b1);
        cyc(2'b00, 7'd0, 8'h00, 7'd0, 8'h00, 2'b11, 7'd40, 7'd40, 8'h55, 8'h55, 1'b1);
        // unwritten neighbour stays zero
        cyc(2'b00, 7'd0, 8'h00, 7'd0, 8'h00, 2'b10, 7'd0, 7'd41, 8'h00, 8'h00, 1'b1);

        // reset mid-operation
        cyc(2'b01, 7'd50, 8'h7F, 7'd0, 8'h00, 2'b00, 7'd0, 7'd0, 8'h00, 8'h00, 1'b0);
        cyc(2'b00, 7'd0, 8'h00, 7'd0, 8'h00, 2'b01, 7'd50, 7'd0, 8'h7F, 8'h00, 1'b1);
        cyc(2'b00, 7'd0, 8'h00, 7'd0, 8'h00, 2'b01, 7'd50, 7'd0, 8'h00, 8'h00, 1'b0);
        @(posedge clk);
        #1;
        rd_en = 2'b00;
        check("pre_reset_valid", 32'(rd_valid[0]), 32'd1);
        check("pre_reset_data", 32'(rd_data[7:0]), 32'h7F);
        #1 rst = 1'b0;
        #1;
        check("async_reset_valid", 32'(rd_valid), 32'd0);
        check("async_reset_data", 32'(rd_data), 32'd0);
        check("async_reset_busy", 32'(init_busy), 32'd1);
        @(posedge clk);
        #1 rst = 1'b1;
        count_init(n);
        check("reinit_cycles", 32'(n), 32'd128);
        cyc(2'b00, 7'd0, 8'h00, 7'd0, 8'h00, 2'b11, 7'd50, 7'd20, 8'h00, 8'h00, 1'b1);
        idle();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("scoreboard_drained", 32'(exp_q0.size() + exp_q1.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/lvt_mpram.md
# lvt_mpram

Parametrised live-value-table multi-port RAM: NW write ports and NR read ports built from 1W1R bank RAMs plus a live value table (LVT) that records, per address, which write port wrote it last. It is the generalised successor of the fixed 2W/1R LVT BRAM, adding:
- arbitrary port counts, width and depth
- a post-reset clearing sweep, so unwritten addresses read as zero
- a defined same-address write conflict rule
- per-port read-valid strobes

It sits between datapath clients and on-chip storage wherever more than one write per cycle is needed.

## Interface
- NW, 2, number of write ports (≥2)
- NR, 1, number of read ports (≥1)
- DEPTH, 128, words per port-visible memory (power of two)
- DW, 8, data width
- AW, $clog2(DEPTH), address width (derived, not overridden)
- clk  in  1  single clock, all logic rising-edge
- rst  in  1  reset, asynchronous assert, active-low (0 = reset); deassertion synchronous to clk externally
- wr_en  in  NW  per-port write enable
- wr_addr  in  NW*AW  port i at [i*AW +: AW]
- wr_data  in  NW*DW  port i at [i*DW +: DW]
- rd_en  in  NR  per-port read enable
- rd_addr  in  NR*AW  port j at [j*AW +: AW]
- rd_data  out  NR*DW  port j at [j*DW +: DW]; holds last read value
- rd_valid  out  NR  one-cycle strobe, rd_data[j] updated this cycle
- init_busy  out  1  high while clearing sweep runs; ports ignored

## Operation
- FSM states: INIT, RUN.
- Reset (rst=0): asynchronously enter INIT and apply these reset values:
  - sweep counter = 0
  - init_busy = 1
  - rd_valid = 0
  - rd_data = 0
  - LVT entries not reset; bank contents not reset
- INIT: each cycle write 0 to address counter in every bank and set LVT[counter] = 0. After counter reaches DEPTH-1, go to RUN with init_busy = 0.
  - wr_en and rd_en are ignored in INIT.
  - rd_valid stays 0.
- RUN, write port i with wr_en[i]:
  - writes wr_data[i] into all NR banks of column i at wr_addr[i]
  - sets LVT[wr_addr[i]] = i
- Same-address writes in one cycle: highest port index wins. All banks are still written, but the LVT records the highest i.
- RUN, read port j with rd_en[j]:
  - bank row j and LVT read port j are both sampled at rd_addr[j]
  - registered output: rd_data[j] = bank[j][LVT value][addr]
- Read-during-write to the same address: returns the old value (read-first), for both the LVT and the banks.
- Multiple read ports may hit the same address; each returns the same value.
- LVT entry width is $clog2(NW) bits. The LVT is register-based, with NW write ports and NR read ports.

## Timing
- Read latency 1:
  - rd_en[j] sampled at edge k
  - rd_data[j] valid and rd_valid[j]=1 after edge k, for exactly one cycle
  - rd_data holds afterwards
- Write-to-read: a write at edge k is visible to a read sampled at edge k+1 or later.
- INIT lasts exactly DEPTH cycles after the first edge with rst=1.
- Reset mid-INIT or mid-RUN: restarts the sweep from address 0. Pending reads are dropped (rd_valid=0).

## Structure
- Package lvt_mpram_pkg:
  - FSM state typedef (INIT, RUN)
  - default parameter constants
  - a clog2-with-minimum-1 function for the LVT width
- Sub-module lvt_bank: simple dual-port 1W1R RAM, DW × DEPTH, synchronous read-first registered output, inferable as block RAM.
  - Instantiated NW*NR times via generate.
  - Bank write port is muxed between the INIT sweep and write port i.
- The LVT, FSM, sweep counter and output mux live in the top module.

## Test plan
- Reset and init:
  - Stimulus: rst=0 for 2 cycles, then release.
  - Required: init_busy is 1 for exactly 128 cycles. A read of addr 5 issued during INIT gives no rd_valid. A read of addr 5 after INIT returns 0 with rd_valid on the following cycle.
- Basic write/read:
  - Stimulus: wr0 addr 10 data 5, then rd0 addr 10 on the next cycle.
  - Required: rd_data[0]=5 one cycle after rd_en; rd_valid high for one cycle.
- Live-value tracking:
  - Stimulus: wr0 addr 20=0x11, then wr1 addr 20=0x22, read; then wr0 addr 20=0x33, read.
  - Required: first read returns 0x22, second returns 0x33.
- Write conflict:
  - Stimulus: wr0 and wr1 both to addr 30 in the same cycle, data 0xAA and 0xBB.
  - Required: a subsequent read returns 0xBB.
- Read-during-write (NR=2):
  - Stimulus: addr 40 holds 0x22. wr0 addr 40=0x44 while rd0 and rd1 both read addr 40 in the same cycle; read again next cycle.
  - Required: both ports return 0x22, then both return 0x44.
- Reset mid-operation:
  - Stimulus: write addr 50=0x7F, then assert rst in the middle of a cycle.
  - Required: rd_valid and rd_data drop to 0 immediately. INIT reruns for the full 128 cycles. A read of addr 50 afterwards returns 0.
